// File: rtl/lock_controller.sv
// lock_controller: serial-bit code lock with timed open window, failure lockout and optional code programming (LOCK_PROGRAM_EN)
module lock_controller #(
  parameter int                  CODE_LEN       = 5,
  parameter logic [CODE_LEN-1:0] DEFAULT_CODE   = 5'b01011,
  parameter int                  MAX_FAILS      = 3,
  parameter int                  UNLOCK_CYCLES  = 8,
  parameter int                  LOCKOUT_CYCLES = 16,
  parameter int                  TIMEOUT_CYCLES = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                zero,
  input  logic                one,
  input  logic                prog_valid,
  input  logic [CODE_LEN-1:0] prog_code,
  output logic                unlocked,
  output logic                locked_out,
  output logic [2:0]          state,
  output logic [1:0]          fail_count
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ENTRY   = 3'd1;
  localparam logic [2:0] CHECK   = 3'd2;
  localparam logic [2:0] OPEN    = 3'd3;
  localparam logic [2:0] LOCKOUT = 3'd4;
  localparam int T_A  = UNLOCK_CYCLES > LOCKOUT_CYCLES ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TMAX = T_A > TIMEOUT_CYCLES ? T_A : TIMEOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int CW   = $clog2(CODE_LEN + 1);
  localparam logic [1:0] MAX_F = 2'(MAX_FAILS);
  logic [2:0]          state_q, state_d;
  logic [1:0]          fail_q, fail_d;
  logic [CODE_LEN-1:0] entry_q, entry_d;
  logic [CODE_LEN-1:0] code_q, code_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                bit_v;
  assign bit_v      = zero ^ one;
  assign state      = state_q;
  assign unlocked   = state_q == OPEN;
  assign locked_out = state_q == LOCKOUT;
  assign fail_count = fail_q;
`ifndef LOCK_PROGRAM_EN
  logic unused_prog;
  assign unused_prog = ^{prog_valid, prog_code};
`endif
  // next-state logic: one shared timer serves the entry timeout, the open window and the lockout period
  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    entry_d = entry_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: if (bit_v) begin
        state_d = ENTRY;
        entry_d = CODE_LEN'(one);
        cnt_d   = CW'(1);
        timer_d = '0;
      end
      ENTRY: if (cnt_q == CW'(CODE_LEN)) begin
        state_d = CHECK;
        timer_d = '0;
      end else if (bit_v) begin
        entry_d = CODE_LEN'({entry_q, one});
        cnt_d   = cnt_q + CW'(1);
        timer_d = '0;
      end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = IDLE;
        entry_d = '0;
        cnt_d   = '0;
        timer_d = '0;
      end else begin
        timer_d = timer_q + TW'(1);
      end
      CHECK: begin
        entry_d = '0;
        cnt_d   = '0;
        timer_d = '0;
        if (entry_q == code_q) begin
          state_d = OPEN;
          fail_d  = '0;
        end else begin
          fail_d  = fail_q == MAX_F ? fail_q : fail_q + 2'd1;
          state_d = fail_q + 2'd1 == MAX_F ? LOCKOUT : IDLE;
        end
      end
      OPEN: begin
`ifdef LOCK_PROGRAM_EN
        code_d = prog_valid ? prog_code : code_q;
`endif
        state_d = timer_q == TW'(UNLOCK_CYCLES - 1) ? IDLE : OPEN;
        timer_d = timer_q == TW'(UNLOCK_CYCLES - 1) ? '0 : timer_q + TW'(1);
      end
      LOCKOUT: if (timer_q == TW'(LOCKOUT_CYCLES - 1)) begin
        state_d = IDLE;
        fail_d  = '0;
        timer_d = '0;
      end else begin
        timer_d = timer_q + TW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers with synchronous reset reloading the default code
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fail_q  <= '0;
      entry_q <= '0;
      code_q  <= DEFAULT_CODE;
      cnt_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      fail_q  <= fail_d;
      entry_q <= entry_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
    end
  end
endmodule

// File: tb/tb_lock_controller.sv
// tb_lock_controller: directed scoreboard bench for lock_controller
module tb_lock_controller;
  localparam logic [2:0] S_IDLE = 3'd0, S_ENTRY = 3'd1, S_CHECK = 3'd2, S_OPEN = 3'd3, S_LOCK = 3'd4;
  logic       clk = 0, rst = 1, zero = 0, one = 0, prog_valid = 0;
  logic [4:0] prog_code = '0;
  logic       unlocked, locked_out;
  logic [2:0] state;
  logic [1:0] fail_count;
  typedef struct packed {logic [2:0] s; logic u; logic l; logic [1:0] f;} exp_t;
  exp_t sb[$];
  int n_vec = 0, n_err = 0;
  string phase = "reset";

  lock_controller dut (
    .clk(clk), .rst(rst), .zero(zero), .one(one),
    .prog_valid(prog_valid), .prog_code(prog_code),
    .unlocked(unlocked), .locked_out(locked_out),
    .state(state), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s/%s observed=%0d expected=%0d", phase, tag, got, exp);
    end
  endtask

  task automatic step(input logic [2:0] es, input logic [1:0] ef);
    exp_t e;
    e.s = es;
    e.u = es == S_OPEN;
    e.l = es == S_LOCK;
    e.f = ef;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("state", state, e.s);
    chk("unlocked", {2'b0, unlocked}, {2'b0, e.u});
    chk("locked_out", {2'b0, locked_out}, {2'b0, e.l});
    chk("fail_count", {1'b0, fail_count}, {1'b0, e.f});
    chk("exclusive", {2'b0, unlocked & locked_out}, 3'd0);
  endtask

  task automatic enter_code(input logic [4:0] c, input logic [1:0] f);
    for (int i = 4; i >= 0; i--) begin
      zero = ~c[i];
      one  = c[i];
      step(S_ENTRY, f);
    end
    zero = 0;
    one  = 0;
  endtask

  task automatic attempt_ok(input logic [4:0] c, input logic [1:0] f);
    enter_code(c, f);
    step(S_CHECK, f);
    repeat (8) step(S_OPEN, 2'd0);
    step(S_IDLE, 2'd0);
  endtask

  task automatic attempt_bad(input logic [4:0] c, input logic [1:0] f);
    enter_code(c, f);
    step(S_CHECK, f);
    if (f == 2'd2) begin
      repeat (16) step(S_LOCK, 2'd3);
      step(S_IDLE, 2'd0);
    end else begin
      step(S_IDLE, f + 2'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    step(S_IDLE, 0);
    step(S_IDLE, 0);
    rst = 0;
    step(S_IDLE, 0);
    phase = "open";
    attempt_ok(5'b01011, 0);
    phase = "fail";
    attempt_bad(5'b11111, 0);
    attempt_bad(5'b11111, 1);
    attempt_bad(5'b11111, 2);
    phase = "timeout";
    attempt_bad(5'b11111, 0);
    zero = 1; step(S_ENTRY, 1);
    zero = 0; one = 1; step(S_ENTRY, 1);
    one = 0;
    repeat (11) step(S_ENTRY, 1);
    step(S_IDLE, 1);
    attempt_ok(5'b01011, 1);
    phase = "noise";
    zero = 1; step(S_ENTRY, 0);
    one = 1; step(S_ENTRY, 0);
    zero = 0; step(S_ENTRY, 0);
    zero = 1; step(S_ENTRY, 0);
    one = 0; step(S_ENTRY, 0);
    one = 1; step(S_ENTRY, 0);
    zero = 0; step(S_ENTRY, 0);
    zero = 1; step(S_ENTRY, 0);
    zero = 0; step(S_ENTRY, 0);
    one = 0; step(S_CHECK, 0);
    one = 1; step(S_OPEN, 0);
    for (int i = 0; i < 7; i++) begin
      zero = i[0];
      one  = ~i[0];
      step(S_OPEN, 0);
    end
    zero = 1; one = 0; step(S_IDLE, 0);
    zero = 0; step(S_IDLE, 0);
    phase = "rst_lockout";
    attempt_bad(5'b00000, 0);
    attempt_bad(5'b10101, 1);
    enter_code(5'b11111, 2);
    step(S_CHECK, 2);
    repeat (4) step(S_LOCK, 3);
    rst = 1; step(S_IDLE, 0);
    rst = 0; step(S_IDLE, 0);
    attempt_ok(5'b01011, 0);
    phase = "rst_entry";
    zero = 1; step(S_ENTRY, 0);
    zero = 0; one = 1; step(S_ENTRY, 0);
    rst = 1; step(S_IDLE, 0);
    rst = 0; one = 0; step(S_IDLE, 0);
    attempt_ok(5'b01011, 0);
    phase = "rst_open";
    enter_code(5'b01011, 0);
    step(S_CHECK, 0);
    repeat (3) step(S_OPEN, 0);
    rst = 1; step(S_IDLE, 0);
    rst = 0; step(S_IDLE, 0);
    phase = "prog_idle";
    prog_valid = 1; prog_code = 5'b11000; step(S_IDLE, 0);
    prog_valid = 0;
    attempt_bad(5'b11000, 0);
    attempt_ok(5'b01011, 1);
    phase = "prog_open";
    enter_code(5'b01011, 0);
    step(S_CHECK, 0);
    step(S_OPEN, 0);
    prog_valid = 1; prog_code = 5'b11000; step(S_OPEN, 0);
    prog_valid = 0;
    repeat (6) step(S_OPEN, 0);
    step(S_IDLE, 0);
`ifdef LOCK_PROGRAM_EN
    attempt_ok(5'b11000, 0);
    attempt_bad(5'b01011, 0);
    rst = 1; step(S_IDLE, 0);
    rst = 0; step(S_IDLE, 0);
    attempt_ok(5'b01011, 0);
`else
    attempt_bad(5'b11000, 0);
    attempt_ok(5'b01011, 1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
